// File: rtl/chunked_adder_defs.sv
// rtl/chunked_adder_defs.sv - shared state encodings and sizing helper for chunked_adder
package chunked_adder_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single chunk still needs one index bit so the register never collapses to zero width.
  function automatic int idx_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunked_adder_ripple_chunk.sv
// rtl/chunked_adder_ripple_chunk.sv - combinational CHUNK-bit ripple adder slice
module ripple_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic p;
    assign p      = a[i] ^ b[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & p);
  end

  // c_msb feeds the signed-overflow test on the top chunk.
  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle add/subtract, CHUNK bits per clock, valid/ready in and out
module chunked_adder
  import chunked_adder_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("chunked_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
  end

  state_e           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             cout_q;
  logic             ovf_q;

  int               base;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] chunk_s_d;
  logic             chunk_co_d;
  logic             chunk_cmsb_d;

  assign base    = int'(idx_q) * CHUNK;
  assign a_slice = opa_q[base +: CHUNK];
  assign b_slice = opb_q[base +: CHUNK];

  ripple_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_slice),
    .b     (b_slice),
    .ci    (carry_q),
    .s     (chunk_s_d),
    .co    (chunk_co_d),
    .c_msb (chunk_cmsb_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1, so cin is replaced by the forced carry.
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[base +: CHUNK] <= chunk_s_d;
          carry_q              <= chunk_co_d;
          idx_q                <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q  <= chunk_co_d;
            ovf_q   <= chunk_co_d ^ chunk_cmsb_d;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
